// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock,
// with start/busy/done handshake and result/flags held until the next completion.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    // state | meaning
    // IDLE  | waiting for start; operands captured on the accepting edge
    // SHIFT | one difference bit per edge, WIDTH edges in total
    // DONE  | one-cycle done pulse; result registers already updated
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic             d_bit;
    logic             br_nx;
    logic [WIDTH-1:0] res_nx;

    assign d_bit  = opa_q[0] ^ opb_q[0] ^ br_q;
    assign br_nx  = (~opa_q[0] & opb_q[0]) | (~(opa_q[0] ^ opb_q[0]) & br_q);
    assign res_nx = {d_bit, res_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    opa_d   = a;
                    opb_d   = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    amsb_d  = a[WIDTH-1];
                    bmsb_d  = b[WIDTH-1];
                end
            end
            SHIFT: begin
                opa_d = opa_q >> 1;
                opb_d = opb_q >> 1;
                br_d  = br_nx;
                res_d = res_nx;
                cnt_d = cnt_q + 1'b1;
                // Last bit: publish result and flags on this same edge.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    diff_d  = res_nx;
                    bout_d  = br_nx;
                    zero_d  = (res_nx == '0);
                    ovf_d   = (amsb_q != bmsb_q) && (res_nx[WIDTH-1] != amsb_q);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;
    assign ovf  = ovf_q;

endmodule
